// File: rtl/key_window_scheduler.sv
// Key bus driver for a time-windowed locked FSM: mirrors the FSM's window counter and
// presents the stored key for the current window every cycle; all outputs registered.
module key_window_scheduler #(
  parameter int KEY_W    = 10,
  parameter int NUM_KEYS = 3,
  parameter int WIN_LEN  = 7,
  parameter int IDX_W    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_wr_en,
  input  logic [IDX_W-1:0] key_wr_idx,
  input  logic [KEY_W-1:0] key_wr_data,
  input  logic             arm,
  input  logic             sync,
  input  logic             zeroize,
  output logic [KEY_W-1:0] key_out,
  output logic [IDX_W-1:0] win_idx,
  output logic [4:0]       ctr_o,
  output logic             running,
  output logic             err
);

  localparam int         PERIOD = NUM_KEYS * WIN_LEN;
  localparam logic [4:0] CTR_MAX = 5'(PERIOD - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_ZERO} state_t;

  state_t             state_q, state_d;
  logic [KEY_W-1:0]   slot_q [NUM_KEYS];
  logic [KEY_W-1:0]   slot_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] valid_q, valid_d;
  logic [KEY_W-1:0]   key_q, key_d;
  logic [IDX_W-1:0]   win_q, win_d;
  logic [4:0]         ctr_q, ctr_d;
  logic               run_q, run_d;
  logic               err_q, err_d;

  logic               wr_idx_ok;
  logic [4:0]         ctr_inc;
  logic [IDX_W-1:0]   win_inc;

  assign wr_idx_ok = int'(key_wr_idx) < NUM_KEYS;
  assign ctr_inc   = (ctr_q == CTR_MAX) ? 5'd0 : ctr_q + 5'd1;
  assign win_inc   = IDX_W'(int'(ctr_inc) / WIN_LEN);

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    valid_d = valid_q;
    key_d   = key_q;
    win_d   = win_q;
    ctr_d   = ctr_q;
    run_d   = run_q;
    err_d   = 1'b0;

    if (zeroize) begin
      state_d = S_ZERO;
      for (int i = 0; i < NUM_KEYS; i++) slot_d[i] = '0;
      valid_d = '0;
      key_d   = '0;
      win_d   = '0;
      ctr_d   = '0;
      run_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (key_wr_en) begin
            if (wr_idx_ok) begin
              slot_d[key_wr_idx]  = key_wr_data;
              valid_d[key_wr_idx] = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
          // Arm qualification uses the mask from before any same-edge write.
          if (arm) begin
            if (&valid_q) begin
              state_d = S_RUN;
              ctr_d   = '0;
              win_d   = '0;
              key_d   = slot_d[0];
              run_d   = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        S_RUN: begin
          if (key_wr_en) err_d = 1'b1;
          if (!arm) begin
            state_d = S_IDLE;
            key_d   = '0;
            win_d   = '0;
            ctr_d   = '0;
            run_d   = 1'b0;
          end else if (sync) begin
            ctr_d = '0;
            win_d = '0;
            key_d = slot_q[0];
          end else begin
            ctr_d = ctr_inc;
            win_d = win_inc;
            key_d = slot_q[win_inc];
          end
        end
        S_ZERO: begin
          state_d = S_IDLE;
          for (int i = 0; i < NUM_KEYS; i++) slot_d[i] = '0;
          valid_d = '0;
          key_d   = '0;
          win_d   = '0;
          ctr_d   = '0;
          run_d   = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_KEYS; i++) slot_q[i] <= '0;
      valid_q <= '0;
      key_q   <= '0;
      win_q   <= '0;
      ctr_q   <= '0;
      run_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < NUM_KEYS; i++) slot_q[i] <= slot_d[i];
      valid_q <= valid_d;
      key_q   <= key_d;
      win_q   <= win_d;
      ctr_q   <= ctr_d;
      run_q   <= run_d;
      err_q   <= err_d;
    end
  end

  assign key_out = key_q;
  assign win_idx = win_q;
  assign ctr_o   = ctr_q;
  assign running = run_q;
  assign err     = err_q;

endmodule

// File: tb/tb_key_window_scheduler.sv
// Table-driven bench for key_window_scheduler; each vector's expectation is queued when
// its inputs are driven and popped/compared one edge later.
module tb_key_window_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_wr_en = 1'b0;
  logic [1:0] key_wr_idx = '0;
  logic [9:0] key_wr_data = '0;
  logic       arm = 1'b0;
  logic       sync = 1'b0;
  logic       zeroize = 1'b0;
  logic [9:0] key_out;
  logic [1:0] win_idx;
  logic [4:0] ctr_o;
  logic       running;
  logic       err;

  key_window_scheduler dut (
    .clk(clk), .rst(rst),
    .key_wr_en(key_wr_en), .key_wr_idx(key_wr_idx), .key_wr_data(key_wr_data),
    .arm(arm), .sync(sync), .zeroize(zeroize),
    .key_out(key_out), .win_idx(win_idx), .ctr_o(ctr_o),
    .running(running), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst, wr_en;
    logic [1:0] wr_idx;
    logic [9:0] wr_data;
    logic       arm, sync, zeroize;
    logic [9:0] e_key;
    logic [1:0] e_win;
    logic [4:0] e_ctr;
    logic       e_run, e_err;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mctr   = 0;
  int   keyv [3] = '{18, 382, 958};

  function automatic void add(string n, bit r, bit we, int wi, int wd, bit a, bit s, bit z,
                              int ek, int ew, int ec, bit er, bit ee);
    vec_t v;
    v.name = n; v.rst = r; v.wr_en = we; v.wr_idx = 2'(wi); v.wr_data = 10'(wd);
    v.arm = a; v.sync = s; v.zeroize = z;
    v.e_key = 10'(ek); v.e_win = 2'(ew); v.e_ctr = 5'(ec); v.e_run = er; v.e_err = ee;
    vecs.push_back(v);
  endfunction

  // Quiet idle cycle: all outputs low unless err is expected.
  function automatic void add_idle(string n, bit we, int wi, int wd, bit a, bit ee);
    add(n, 1, we, wi, wd, a, 0, 0, 0, 0, 0, 0, ee);
  endfunction

  // Plain RUN cycles: counter advances and wraps after 20, key follows ctr/7.
  function automatic void add_run(string n, int count);
    for (int i = 0; i < count; i++) begin
      mctr = (mctr == 20) ? 0 : mctr + 1;
      add(n, 1, 0, 0, 0, 1, 0, 0, keyv[mctr / 7], mctr / 7, mctr, 1, 0);
    end
  endfunction

  task automatic chk(string n, string f, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d, expected %0d", n, f, act, exp);
    end
  endtask

  initial begin
    vec_t e;

    add("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add_idle("idle", 0, 0, 0, 0, 0);
    add_idle("load0", 1, 0, 18, 0, 0);
    add_idle("load1", 1, 1, 382, 0, 0);
    add_idle("arm_missing", 0, 0, 0, 1, 1);
    add_idle("err_pulse_end", 0, 0, 0, 0, 0);
    add_idle("bad_idx", 1, 3, 77, 0, 1);
    add_idle("wr_arm_same_edge", 1, 2, 958, 1, 1);
    add("arm_ok", 1, 0, 0, 0, 1, 0, 0, 18, 0, 0, 1, 0);
    mctr = 0;
    add_run("period", 21);
    add_run("to_ctr12", 12);
    add("sync", 1, 0, 0, 0, 1, 1, 0, 18, 0, 0, 1, 0);
    mctr = 0;
    add_run("after_sync", 7);
    add_run("to_ctr15", 8);
    add("wr_in_run", 1, 1, 0, 5, 1, 0, 0, 958, 2, 16, 1, 1);
    mctr = 16;
    add_run("wr_no_effect", 5);
    add_run("to_ctr9", 9);
    add("zeroize", 1, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    add_idle("zero_state", 0, 0, 0, 0, 0);
    add_idle("rearm_no_keys", 0, 0, 0, 1, 1);
    add_idle("idle2", 0, 0, 0, 0, 0);
    add_idle("reload0", 1, 0, 18, 0, 0);
    add_idle("reload1", 1, 1, 382, 0, 0);
    add_idle("reload2", 1, 2, 958, 0, 0);
    add("arm2", 1, 0, 0, 0, 1, 0, 0, 18, 0, 0, 1, 0);
    mctr = 0;
    add_run("run2", 3);
    add_idle("disarm", 0, 0, 0, 0, 0);
    add("rearm_kept", 1, 0, 0, 0, 1, 0, 0, 18, 0, 0, 1, 0);
    mctr = 0;
    add_run("to_ctr16", 16);
    add("rst_in_run", 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    add_idle("arm_after_rst", 0, 0, 0, 1, 1);
    add_idle("idle3", 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst         = vecs[i].rst;
      key_wr_en   = vecs[i].wr_en;
      key_wr_idx  = vecs[i].wr_idx;
      key_wr_data = vecs[i].wr_data;
      arm         = vecs[i].arm;
      sync        = vecs[i].sync;
      zeroize     = vecs[i].zeroize;
      sb.push_back(vecs[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk(e.name, "key_out", 32'(key_out), 32'(e.e_key));
      chk(e.name, "win_idx", 32'(win_idx), 32'(e.e_win));
      chk(e.name, "ctr_o",   32'(ctr_o),   32'(e.e_ctr));
      chk(e.name, "running", 32'(running), 32'(e.e_run));
      chk(e.name, "err",     32'(err),     32'(e.e_err));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
